// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM state type and table-slicing helpers for the
// multi-command UART responder.
package uart_cmd_pkg;
  localparam int DW_DEF = 8;
  localparam int DW_MAX = 16;
  localparam int LEN_W  = 5;
  localparam int TBL_W  = 8 * 16 * DW_MAX;

  localparam logic [7:0] CHR_CR = 8'h0d;
  localparam logic [7:0] CHR_LF = 8'h0a;

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  // Tables are zero-extended to TBL_W so one helper serves every configuration.
  function automatic logic [DW_MAX-1:0] tbl_chr(input logic [TBL_W-1:0] tbl,
                                                input int maxlen, input int dw,
                                                input int i, input int j);
    logic [TBL_W-1:0] s;
    s = tbl >> ((i * maxlen + j) * dw);
    return s[DW_MAX-1:0];
  endfunction

  function automatic logic [DW_MAX-1:0] cmd_chr(input logic [TBL_W-1:0] tbl,
                                                input int cmd_max, input int dw,
                                                input int i, input int j);
    return tbl_chr(tbl, cmd_max, dw, i, j);
  endfunction

  function automatic logic [DW_MAX-1:0] rsp_chr(input logic [TBL_W-1:0] tbl,
                                                input int rsp_max, input int dw,
                                                input int i, input int j);
    return tbl_chr(tbl, rsp_max, dw, i, j);
  endfunction
endpackage

// File: rtl/uart_cmd_resp_if.sv
// Byte-level handshake bundle between the responder and the UART RX/TX wrappers.
interface uart_cmd_resp_if
  import uart_cmd_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          tx_rdy;
  logic          tx_we;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic          cmd_hit;
  logic [2:0]    cmd_idx;
  logic          ovf;

  modport slave (
    input  rx_valid, rx_data, tx_rdy,
    output tx_we, tx_data, busy, cmd_hit, cmd_idx, ovf
  );

  modport master (
    output rx_valid, rx_data, tx_rdy,
    input  tx_we, tx_data, busy, cmd_hit, cmd_idx, ovf
  );
endinterface

// File: rtl/uart_cmd_resp_matcher.sv
// Single-command pointer matcher with one-character restart on mismatch.
module cmd_matcher
  import uart_cmd_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int CMD_MAX = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_valid_i,
  input  logic [DW-1:0]         rx_data_i,
  input  logic                  clr_i,
  input  logic [CMD_MAX*DW-1:0] str_i,
  input  logic [LEN_W-1:0]      len_i,
  output logic                  match_o
);
  localparam int PW = $clog2(CMD_MAX + 1);

  logic [PW-1:0] p_q, p_d, p_nxt;
  logic [DW-1:0] c_cur, c_first;

  always_comb begin
    c_cur   = DW'(cmd_chr(TBL_W'(str_i), CMD_MAX, DW, 0, int'(p_q)));
    c_first = DW'(cmd_chr(TBL_W'(str_i), CMD_MAX, DW, 0, 0));
    match_o = 1'b0;
    p_nxt   = p_q;
    if (rx_valid_i) begin
      if (rx_data_i == c_cur) begin
        if (int'(p_q) == int'(len_i) - 1) match_o = 1'b1;
        else                              p_nxt   = p_q + PW'(1);
      end else if (rx_data_i == c_first) begin
        if (len_i == LEN_W'(1)) match_o = 1'b1;
        else                    p_nxt   = PW'(1);
      end else begin
        p_nxt = '0;
      end
    end
  end

  // Kept apart from the match logic: clr depends on every matcher's match.
  assign p_d = clr_i ? '0 : p_nxt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) p_q <= '0;
    else         p_q <= p_d;
  end
endmodule

// File: rtl/uart_cmd_resp.sv
// Multi-command responder: NCMD matchers, lowest-index hit priority, a
// 1-deep pending slot and a two-state transmit FSM feeding the UART TX.
module uart_cmd_resp
  import uart_cmd_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int NCMD    = 4,
  parameter int CMD_MAX = 8,
  parameter int RSP_MAX = 8,
  parameter logic [NCMD*CMD_MAX*DW-1:0] CMD_TABLE = '0,
  parameter logic [NCMD*LEN_W-1:0]      CMD_LENS  = '0,
  parameter logic [NCMD*RSP_MAX*DW-1:0] RSP_TABLE = '0,
  parameter logic [NCMD*LEN_W-1:0]      RSP_LENS  = '0
) (
  input  logic            CLK,
  input  logic            RST_X,
  uart_cmd_resp_if.slave  bus
);
  localparam int RW = $clog2(RSP_MAX + 1);
  localparam logic [TBL_W-1:0] RSP_TBL = TBL_W'(RSP_TABLE);

  if (NCMD < 1 || NCMD > 8 || CMD_MAX < 1 || CMD_MAX > 16 ||
      RSP_MAX < 1 || RSP_MAX > 16 || DW < 1 || DW > DW_MAX) begin : g_bad_cfg
    $error("uart_cmd_resp: parameter out of range");
  end

  logic [NCMD-1:0] match;
  logic            hit_any;
  logic [2:0]      hidx;

  // An all-zero length vector is the unconfigured default; anything else must be in range.
  for (genvar g = 0; g < NCMD; g++) begin : g_cmd
    localparam int CL = int'(CMD_LENS[g*LEN_W +: LEN_W]);
    localparam int RL = int'(RSP_LENS[g*LEN_W +: LEN_W]);
    if (CMD_LENS != '0 && (CL < 1 || CL > CMD_MAX)) begin : g_bad_cl
      $error("uart_cmd_resp: command length out of range");
    end
    if (RL > RSP_MAX) begin : g_bad_rl
      $error("uart_cmd_resp: response length out of range");
    end
    cmd_matcher #(.DW(DW), .CMD_MAX(CMD_MAX)) u_match (
      .clk_i      (CLK),
      .rst_ni     (RST_X),
      .rx_valid_i (bus.rx_valid),
      .rx_data_i  (bus.rx_data),
      .clr_i      (hit_any),
      .str_i      (CMD_TABLE[g*CMD_MAX*DW +: CMD_MAX*DW]),
      .len_i      (CMD_LENS[g*LEN_W +: LEN_W]),
      .match_o    (match[g])
    );
  end

  assign hit_any = |match;

  always_comb begin
    hidx = '0;
    for (int k = NCMD - 1; k >= 0; k--) if (match[k]) hidx = 3'(k);
  end

  state_e           st_q, st_d;
  logic [2:0]       sel_q, sel_d, pidx_q, pidx_d, hidx_q;
  logic             pend_q, pend_d, hit_q, ovf_q, ovf_d, last;
  logic [RW-1:0]    wptr_q, wptr_d;
  logic [LEN_W-1:0] rlen_sel, rlen_hit;

  assign rlen_sel    = LEN_W'(RSP_LENS >> (LEN_W * int'(sel_q)));
  assign rlen_hit    = LEN_W'(RSP_LENS >> (LEN_W * int'(hidx)));
  assign last        = int'(wptr_q) == int'(rlen_sel) - 1;
  assign bus.busy    = (st_q == ST_SEND);
  assign bus.tx_we   = bus.busy & bus.tx_rdy;
  assign bus.tx_data = DW'(rsp_chr(RSP_TBL, RSP_MAX, DW, int'(sel_q), int'(wptr_q)));
  assign bus.cmd_hit = hit_q;
  assign bus.cmd_idx = hidx_q;
  assign bus.ovf     = ovf_q;

  always_comb begin
    st_d   = st_q;
    sel_d  = sel_q;
    wptr_d = wptr_q;
    pend_d = pend_q;
    pidx_d = pidx_q;
    ovf_d  = 1'b0;
    if (st_q == ST_SEND && bus.tx_we) begin
      if (!last) begin
        wptr_d = wptr_q + RW'(1);
      end else if (pend_q) begin
        sel_d  = pidx_q;
        wptr_d = '0;
        pend_d = 1'b0;
      end else begin
        st_d   = ST_IDLE;
        wptr_d = '0;
      end
    end
    // A hit on a finishing response's last byte starts it back-to-back.
    if (hit_any && rlen_hit != '0) begin
      if (st_d == ST_IDLE) begin
        st_d   = ST_SEND;
        sel_d  = hidx;
        wptr_d = '0;
      end else if (!pend_d) begin
        pend_d = 1'b1;
        pidx_d = hidx;
      end else begin
        ovf_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      st_q   <= ST_IDLE;
      sel_q  <= '0;
      wptr_q <= '0;
      pend_q <= 1'b0;
      pidx_q <= '0;
      hit_q  <= 1'b0;
      hidx_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      sel_q  <= sel_d;
      wptr_q <= wptr_d;
      pend_q <= pend_d;
      pidx_q <= pidx_d;
      hit_q  <= hit_any;
      hidx_q <= hidx;
      ovf_q  <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_cmd_resp.sv
// Directed plus randomized bench for uart_cmd_resp against a byte-queue model
// of the responder: matcher pointers, one active response queue, one pending slot.
module tb_uart_cmd_resp;
  import uart_cmd_pkg::*;

  localparam logic [255:0] CMD_T = {64'({CHR_LF, CHR_CR, "Z", "Z"}), 64'("Q"),
                                    64'({CHR_LF, CHR_CR, "D", "I"}),
                                    64'({CHR_LF, CHR_CR, "R", "E", "V"})};
  localparam logic [255:0] RSP_T = {64'({CHR_LF, CHR_CR, "!", "Z"}), 64'(0),
                                    64'({CHR_LF, CHR_CR, "K", "O"}),
                                    64'({CHR_LF, CHR_CR, "0", ".", "1", "V"})};
  localparam logic [19:0] CL = {5'd4, 5'd1, 5'd4, 5'd5};
  localparam logic [19:0] RL = {5'd4, 5'd0, 5'd4, 5'd6};

  logic clk = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_resp_if #(.DW(8)) bus ();

  uart_cmd_resp #(
    .DW(8), .NCMD(4), .CMD_MAX(8), .RSP_MAX(8),
    .CMD_TABLE(CMD_T), .CMD_LENS(CL), .RSP_TABLE(RSP_T), .RSP_LENS(RL)
  ) dut (
    .CLK   (clk),
    .RST_X (rst_x),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_ovf = 0;
  logic alt = 1'b0;
  logic [7:0] txlog[$];
  int         hitlog[$];
  logic [7:0] sq[$];

  // Reference model state
  int         ptr[4];
  logic       busy_m, pend_m, hit_m, ovf_m;
  int         pidx_m, hidx_m;
  logic [7:0] cur_q[$];

  logic [7:0] VER_RSP[6] = '{8'h56, 8'h31, 8'h2E, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] ID_RSP[4]  = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};

  function automatic logic [7:0] cmdc(input int i, input int j);
    logic [255:0] s;
    s = CMD_T >> ((i * 8 + j) * 8);
    return s[7:0];
  endfunction

  function automatic logic [7:0] rspc(input int i, input int j);
    logic [255:0] s;
    s = RSP_T >> ((i * 8 + j) * 8);
    return s[7:0];
  endfunction

  function automatic int clen(input int i);
    return int'(5'(CL >> (5 * i)));
  endfunction

  function automatic int rlen(input int i);
    return int'(5'(RL >> (5 * i)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ptr[i] = 0;
    busy_m = 0; pend_m = 0; hit_m = 0; ovf_m = 0;
    pidx_m = 0; hidx_m = 0;
    cur_q.delete();
  endtask

  task automatic model_load(input int k);
    cur_q.delete();
    for (int j = 0; j < rlen(k); j++) cur_q.push_back(rspc(k, j));
    busy_m = 1;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
    int win;
    int np[4];
    logic m[4];
    if (busy_m && r) begin
      void'(cur_q.pop_front());
      if (cur_q.size() == 0) begin
        if (pend_m) begin model_load(pidx_m); pend_m = 0; end
        else busy_m = 0;
      end
    end
    hit_m = 0; ovf_m = 0; win = -1;
    if (v) begin
      for (int i = 0; i < 4; i++) begin
        m[i] = 0; np[i] = ptr[i];
        if (d == cmdc(i, ptr[i])) begin
          if (ptr[i] == clen(i) - 1) m[i] = 1; else np[i] = ptr[i] + 1;
        end else if (d == cmdc(i, 0)) begin
          if (clen(i) == 1) m[i] = 1; else np[i] = 1;
        end else np[i] = 0;
      end
      for (int i = 3; i >= 0; i--) if (m[i]) win = i;
      for (int i = 0; i < 4; i++) ptr[i] = (win >= 0) ? 0 : np[i];
    end
    if (win >= 0) begin
      hit_m = 1; hidx_m = win;
      if (rlen(win) > 0) begin
        if (!busy_m) model_load(win);
        else if (!pend_m) begin pend_m = 1; pidx_m = win; end
        else ovf_m = 1;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    bus.rx_valid = v; bus.rx_data = d; bus.tx_rdy = r;
    #3;
    chk("busy", 32'(bus.busy), 32'(busy_m));
    chk("tx_we", 32'(bus.tx_we), 32'(busy_m && r));
    if (busy_m) chk("tx_data", 32'(bus.tx_data), 32'(cur_q[0]));
    chk("cmd_hit", 32'(bus.cmd_hit), 32'(hit_m));
    if (hit_m) chk("cmd_idx", 32'(bus.cmd_idx), 32'(hidx_m));
    chk("ovf", 32'(bus.ovf), 32'(ovf_m));
    if (bus.tx_we === 1'b1) txlog.push_back(bus.tx_data);
    if (bus.cmd_hit === 1'b1) hitlog.push_back(int'(bus.cmd_idx));
    if (bus.ovf === 1'b1) n_ovf++;
    model_edge(v, d, r);
    @(posedge clk); #1;
  endtask

  task automatic get_rdy(input int mode, output logic r);
    case (mode)
      0: r = 1'b1;
      1: r = 1'b0;
      2: begin alt = ~alt; r = alt; end
      default: r = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic set_cmd(input int k);
    sq.delete();
    for (int j = 0; j < clen(k); j++) sq.push_back(cmdc(k, j));
  endtask

  task automatic send(input int mode, input bit gaps);
    logic r;
    foreach (sq[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin get_rdy(mode, r); cyc(1'b0, 8'h00, r); end
      get_rdy(mode, r);
      cyc(1'b1, sq[i], r);
    end
  endtask

  task automatic idle(input int n, input int mode);
    logic r;
    for (int i = 0; i < n; i++) begin get_rdy(mode, r); cyc(1'b0, 8'h00, r); end
  endtask

  task automatic clr_logs();
    txlog.delete(); hitlog.delete(); n_ovf = 0;
  endtask

  task automatic chk_bytes_ver(input string tag, input int off);
    for (int j = 0; j < 6; j++)
      if (txlog.size() > off + j) chk(tag, 32'(txlog[off+j]), 32'(VER_RSP[j]));
  endtask

  initial begin
    logic [7:0] noise[10] = '{"V", "E", "R", "I", "D", "Q", "Z", "X", CHR_CR, CHR_LF};
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1; rst_x = 1'b1;

    // reset state
    idle(2, 0);

    // basic VER\r\n with tx_rdy=1
    clr_logs();
    set_cmd(0); send(0, 0);
    idle(10, 0);
    chk("ver_hits", 32'(hitlog.size()), 32'd1);
    chk("ver_nbytes", 32'(txlog.size()), 32'd6);
    chk_bytes_ver("ver_byte", 0);

    // restart on VVER\r\n
    clr_logs();
    sq = '{"V", "V", "E", "R", CHR_CR, CHR_LF}; send(0, 0);
    idle(10, 0);
    chk("vver_hits", 32'(hitlog.size()), 32'd1);
    chk("vver_nbytes", 32'(txlog.size()), 32'd6);

    // no hit on VEX\r\n
    clr_logs();
    sq = '{"V", "E", "X", CHR_CR, CHR_LF}; send(0, 0);
    idle(4, 0);
    chk("vex_hits", 32'(hitlog.size()), 32'd0);
    chk("vex_nbytes", 32'(txlog.size()), 32'd0);

    // tx_rdy alternating during the response
    clr_logs();
    set_cmd(0); send(2, 0);
    idle(16, 2);
    chk("stall_nbytes", 32'(txlog.size()), 32'd6);
    chk_bytes_ver("stall_byte", 0);

    // pending slot and overflow while stalled
    clr_logs();
    set_cmd(0); send(1, 0);
    set_cmd(1); send(1, 0);
    set_cmd(1); send(1, 0);
    set_cmd(0); send(1, 0);
    idle(16, 0);
    chk("pend_ovf", 32'(n_ovf), 32'd2);
    chk("pend_nbytes", 32'(txlog.size()), 32'd10);
    chk_bytes_ver("pend_first", 0);
    for (int j = 0; j < 4; j++)
      if (txlog.size() > 6 + j) chk("pend_second", 32'(txlog[6+j]), 32'(ID_RSP[j]));

    // reset after the second response byte
    clr_logs();
    set_cmd(0); send(0, 0);
    idle(2, 0);
    chk("rst_pre_nbytes", 32'(txlog.size()), 32'd2);
    rst_x = 1'b0; bus.rx_valid = 1'b0; bus.tx_rdy = 1'b0;
    @(posedge clk); #1;
    rst_x = 1'b1;
    model_reset();
    idle(2, 0);
    chk("rst_post_nbytes", 32'(txlog.size()), 32'd2);
    clr_logs();
    set_cmd(0); send(0, 0);
    idle(10, 0);
    chk("rst_fresh_nbytes", 32'(txlog.size()), 32'd6);
    chk_bytes_ver("rst_fresh_byte", 0);

    // hit-only command
    clr_logs();
    set_cmd(2); send(0, 0);
    idle(3, 0);
    chk("q_hits", 32'(hitlog.size()), 32'd1);
    if (hitlog.size() > 0) chk("q_idx", 32'(hitlog[0]), 32'd2);
    chk("q_nbytes", 32'(txlog.size()), 32'd0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 5);
      if (k < 4) set_cmd(k);
      else begin
        sq.delete();
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) sq.push_back(noise[$urandom_range(0, 9)]);
      end
      send(3, 1);
    end
    idle(40, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
